// File: rtl/vec_sequencer_pkg.sv
// Shared SIMD definitions: ALU opcodes, sequencer states and the read-to-result pipeline depth.
// Used by the vector sequencer and by the PE lane array.
package vec_sequencer_pkg;

    localparam int PIPE_LAT = 2;

    typedef enum logic [3:0] {
        OP_NOOP = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_MUL  = 4'd3,
        OP_DOTP = 4'd4
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DOTP_WR,
        ST_DONE
    } seq_state_e;

    function automatic logic is_valid_op(input logic [31:0] op);
        return (op >= 32'(OP_ADD)) && (op <= 32'(OP_DOTP));
    endfunction

endpackage

// File: rtl/vec_addr_gen.sv
// Row address counter: loads a base row, then advances by one per step,
// wrapping modulo 2^ADDR_WIDTH.
module vec_addr_gen #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_base,
    input  logic                  i_step,
    output logic [ADDR_WIDTH-1:0] o_addr
);

    logic [ADDR_WIDTH-1:0] r_addr;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
        end else if (i_load) begin
            r_addr <= i_base;
        end else if (i_step) begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
        end
    end

    assign o_addr = r_addr;

endmodule

// File: rtl/vec_sequencer.sv
// Vector command sequencer: streams rows from RAMs A/B through the PE lanes and
// writes per-row results (ADD/SUB/MUL) or one dot-product row (DOTP).
module vec_sequencer
    import vec_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int PE_ELEMENTS     = 4,
    parameter int DRAM_ADDR_WIDTH = 8,
    parameter int OPCODE_WIDTH    = 4,
    parameter int LEN_WIDTH       = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    cmd_valid,
    output logic                                    cmd_ready,
    input  logic [OPCODE_WIDTH-1:0]                 cmd_opcode,
    input  logic [DRAM_ADDR_WIDTH-1:0]              cmd_a_base,
    input  logic [DRAM_ADDR_WIDTH-1:0]              cmd_b_base,
    input  logic [DRAM_ADDR_WIDTH-1:0]              cmd_r_base,
    input  logic [LEN_WIDTH-1:0]                    cmd_len,
    output logic                                    ram_a_rd_en,
    output logic                                    ram_b_rd_en,
    output logic [DRAM_ADDR_WIDTH-1:0]              ram_a_read_addr,
    output logic [DRAM_ADDR_WIDTH-1:0]              ram_b_read_addr,
    output logic [OPCODE_WIDTH-1:0]                 pe_opcode,
    input  logic [PE_ELEMENTS-1:0][DATA_WIDTH-1:0]  pe_result,
    output logic                                    ram_result_wr_en,
    output logic [DRAM_ADDR_WIDTH-1:0]              ram_result_write_addr,
    output logic [PE_ELEMENTS-1:0][DATA_WIDTH-1:0]  ram_result_write_data,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    cmd_err
);

    seq_state_e                 r_state, w_next_state;
    logic [OPCODE_WIDTH-1:0]    r_opcode;
    logic [LEN_WIDTH-1:0]       r_len, r_issue_cnt;
    logic                       r_err;
    logic [DATA_WIDTH-1:0]      r_acc, w_lane_sum;
    logic [PIPE_LAT-1:0]        r_pipe_valid;
    logic [DRAM_ADDR_WIDTH-1:0] w_a_addr, w_b_addr, w_r_addr;
    logic w_idle, w_accept, w_cmd_bad, w_issue, w_last_issue;
    logic w_retire, w_is_dotp, w_row_wr, w_dotp_wr;

    assign w_idle       = (r_state == ST_IDLE);
    assign w_accept     = cmd_valid && w_idle;
    assign w_cmd_bad    = !is_valid_op(32'(cmd_opcode));
    assign w_issue      = (r_state == ST_ISSUE);
    assign w_last_issue = w_issue && (r_issue_cnt == r_len - LEN_WIDTH'(1));
    assign w_retire     = r_pipe_valid[PIPE_LAT-1];
    assign w_is_dotp    = (r_opcode == OPCODE_WIDTH'(OP_DOTP));
    assign w_row_wr     = w_retire && !w_is_dotp;
    assign w_dotp_wr    = (r_state == ST_DOTP_WR);

    vec_addr_gen #(.ADDR_WIDTH(DRAM_ADDR_WIDTH)) u_addr_a (
        .clk(clk), .rst(rst), .i_load(w_accept), .i_base(cmd_a_base), .i_step(w_issue), .o_addr(w_a_addr)
    );
    vec_addr_gen #(.ADDR_WIDTH(DRAM_ADDR_WIDTH)) u_addr_b (
        .clk(clk), .rst(rst), .i_load(w_accept), .i_base(cmd_b_base), .i_step(w_issue), .o_addr(w_b_addr)
    );
    // The result counter advances only as row writes retire, so DOTP_WR still sees r_base.
    vec_addr_gen #(.ADDR_WIDTH(DRAM_ADDR_WIDTH)) u_addr_r (
        .clk(clk), .rst(rst), .i_load(w_accept), .i_base(cmd_r_base), .i_step(w_row_wr), .o_addr(w_r_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        w_next_state = r_state;
        cmd_ready    = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        cmd_err      = 1'b0;
        pe_opcode    = '0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    w_next_state = (w_cmd_bad || cmd_len == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                pe_opcode = r_opcode;
                if (w_last_issue) w_next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                pe_opcode = r_opcode;
                if (r_pipe_valid == '0) w_next_state = w_is_dotp ? ST_DOTP_WR : ST_DONE;
            end
            ST_DOTP_WR: w_next_state = ST_DONE;
            ST_DONE: begin
                done         = 1'b1;
                cmd_err      = r_err;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_lane_sum = '0;
        for (int i = 0; i < PE_ELEMENTS; i++) begin
            w_lane_sum = w_lane_sum + pe_result[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opcode     <= '0;
            r_len        <= '0;
            r_err        <= 1'b0;
            r_issue_cnt  <= '0;
            r_acc        <= '0;
            r_pipe_valid <= '0;
        end else begin
            r_pipe_valid <= {r_pipe_valid[PIPE_LAT-2:0], w_issue};
            if (w_accept) begin
                r_opcode    <= cmd_opcode;
                r_len       <= cmd_len;
                r_err       <= w_cmd_bad;
                r_issue_cnt <= '0;
                r_acc       <= '0;
            end else begin
                if (w_issue) r_issue_cnt <= r_issue_cnt + LEN_WIDTH'(1);
                if (w_retire && w_is_dotp) r_acc <= r_acc + w_lane_sum;
            end
        end
    end

    assign ram_a_rd_en           = w_issue;
    assign ram_b_rd_en           = w_issue;
    assign ram_a_read_addr       = w_issue ? w_a_addr : '0;
    assign ram_b_read_addr       = w_issue ? w_b_addr : '0;
    assign ram_result_wr_en      = w_row_wr || w_dotp_wr;
    assign ram_result_write_addr = ram_result_wr_en ? w_r_addr : '0;

    always_comb begin
        ram_result_write_data = '0;
        if (w_row_wr) begin
            ram_result_write_data = pe_result;
        end else if (w_dotp_wr) begin
            ram_result_write_data[0] = r_acc;
        end
    end

endmodule

// File: doc/vec_sequencer.md
VEC_SEQUENCER -- requirements
Module: vec_sequencer

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, lane width.
REQ-002 Parameter: PE_ELEMENTS, default 4, lanes per row.
REQ-003 Parameter: DRAM_ADDR_WIDTH, default 8, row address width for RAMs A, B and result.
REQ-004 Parameter: OPCODE_WIDTH, default 4, opcode width.
REQ-005 Parameter: LEN_WIDTH, default 8, row-count width.
REQ-006 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 Port: rst  in  1  asynchronous, active-high reset.
REQ-008 Port: cmd_valid  in  1 / cmd_ready  out  1, which form the command handshake.
REQ-009 Port: cmd_opcode  in  OPCODE_WIDTH  operation: ADD=1, SUB=2, MUL=3, DOTP=4.
REQ-010 Port: cmd_a_base, cmd_b_base, cmd_r_base  in  DRAM_ADDR_WIDTH  start rows.
REQ-011 Port: cmd_len  in  LEN_WIDTH  number of rows to process.
REQ-012 Port: ram_a_rd_en, ram_b_rd_en  out  1; ram_a_read_addr, ram_b_read_addr  out  DRAM_ADDR_WIDTH.
REQ-013 Port: pe_opcode  out  OPCODE_WIDTH  opcode presented to the ALU lanes.
REQ-014 Port: pe_result  in  PE_ELEMENTS x DATA_WIDTH  registered ALU lane outputs.
REQ-015 Port: ram_result_wr_en  out  1; ram_result_write_addr  out  DRAM_ADDR_WIDTH; ram_result_write_data  out  PE_ELEMENTS x DATA_WIDTH.
REQ-016 Port: busy  out  1; done  out  1 (single-cycle pulse); cmd_err  out  1 (valid with done).

Function
REQ-017 FSM states: IDLE, ISSUE, DRAIN, DOTP_WR, DONE.
REQ-018 IDLE: cmd_ready=1 and busy=0. A command is accepted when cmd_valid&&cmd_ready; all cmd_* fields are latched on acceptance.
REQ-019 Accepted with cmd_len=0 or an opcode outside 1..4: go directly to DONE with no RAM access; cmd_err=1 only for a bad opcode.
REQ-020 ISSUE: one row per cycle; rd_en A/B=1, addresses base+i for i=0..len-1, modulo 2^DRAM_ADDR_WIDTH (wraps).
REQ-021 pe_opcode equals the latched opcode from ISSUE entry through the end of DRAIN; it is 0 (NOOP) otherwise.
REQ-022 Pipeline latency: RAM read issued at cycle t yields pe_result at t+2. A 2-deep valid/index shift register tracks in-flight rows.
REQ-023 ADD/SUB/MUL: at t+2, ram_result_wr_en=1, write_addr=r_base+i (wrapping), write_data=pe_result.
REQ-024 DOTP: no per-row writes; the accumulator adds the sum of all lanes of pe_result for every valid row, modulo 2^DATA_WIDTH. The accumulator clears on acceptance.
REQ-025 After the last row is issued, ISSUE goes to DRAIN; DRAIN waits until the in-flight pipe is empty (2 cycles).
REQ-026 After DRAIN: DOTP goes to DOTP_WR; other opcodes go to DONE.
REQ-027 DOTP_WR: one write to r_base, lane0=accumulator, other lanes=0; then go to DONE.
REQ-028 DONE: done=1 for one cycle, then return to IDLE; cmd_ready=0 in every state except IDLE.
REQ-029 busy=1 in every state except IDLE.
REQ-030 A cmd_valid asserted while busy is ignored and not lost; the command is accepted in the first IDLE cycle.
REQ-031 Read and write addresses are independent, so overlapping source/destination ranges are permitted. No hazard checking is performed.

Reset
REQ-032 rst asserted at any time forces IDLE, clears the accumulator and in-flight pipe, and drives all outputs to 0 except cmd_ready=1; in-flight writes are discarded.
REQ-033 The first accept is possible in the first clock edge after rst deasserts.

Structure
REQ-034 The opcode enum (NOOP, ADD, SUB, MUL, DOTP, ...) and the PIPE_LAT=2 constant live in the shared SIMD package, which pe_top also uses.
REQ-035 One sub-module: vec_addr_gen, the base+index wrapping counter, instantiated for A, B and result.

Verification
REQ-036 ADD, a_base=0, b_base=16, r_base=32, len=3: reads rows 0-2/16-18 at cycles 1-3; writes rows 32-34 at cycles 3-5; done at cycle 7.
REQ-037 DOTP, len=2, pe_result rows {1,2,3,4} and {5,6,7,8}: a single write to r_base with data {0,0,0,36}; no other writes.
REQ-038 len=0, and separately opcode=9: no rd_en/wr_en; done next cycle; cmd_err=0 and 1 respectively.
REQ-039 a_base=254, len=4: read addresses 254, 255, 0, 1.
REQ-040 rst asserted mid-ISSUE of a len=10 MUL: outputs 0 that cycle, no further writes; a new command is accepted after release.
REQ-041 cmd_valid held through a busy window: exactly one accept, in the IDLE cycle after done.
